bcd_7seg_scan_driver: RTL and testbench

Consumes packed BCD digits from the bin2bcd converter through a valid/ready handshake and drives a time-multiplexed common-anode/cathode 7-segment display. It buffers one pending value so that the display updates only at frame boundaries and never tears. It also blanks leading zeros and shows an error glyph for non-decimal nibbles. It sits directly downstream of the bin2bcd stage and is the last stage before the board pins.

---
 rtl/bcd_7seg_scan_driver_pkg.sv | 45 ++++
 rtl/bcd_7seg_scan_driver_to_7seg.sv | 12 +
 rtl/bcd_7seg_scan_driver.sv | 158 +++++++++++++++
 tb/tb_bcd_7seg_scan_driver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_7seg_scan_driver_pkg.sv
// Shared types, glyph table and nibble decode for the 7-segment scan driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied at the pins.
package bcd_7seg_scan_driver_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [0:0] {
    DARK_S = 1'b0,
    SCAN_S = 1'b1
  } bcd_7seg_state_e;

  localparam logic [SEG_W-1:0] SEG_0   = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1   = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2   = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3   = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4   = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5   = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6   = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7   = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9   = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_E   = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

  // Non-decimal nibbles (10..15) render as 'E'.
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [NIBBLE_W-1:0] nibble);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_7seg_scan_driver_to_7seg.sv
// Combinational nibble -> active-high 7-segment glyph.
// Ports: nibble (4-bit BCD digit), seg ({g,f,e,d,c,b,a}, active-high).
module bcd_to_7seg
  import bcd_7seg_scan_driver_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg
);

  assign seg = bcd_to_seg(nibble);

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed 7-segment driver fed by packed BCD over valid/ready.
// A one-deep shadow register holds the next value; it moves to the display
// register only at frame boundaries so a frame never mixes two values.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bcd_valid_i/ready_o  input handshake (ready = shadow empty)
//   bcd_i, blank_lz_i    packed BCD digits and leading-zero blank flag
//   seg_o, an_o          registered segment / digit-enable pins
module bcd_7seg_scan_driver
  import bcd_7seg_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_CYCLES = 50000,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bcd_valid_i,
  output logic                         bcd_ready_o,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] bcd_i,
  input  logic                         blank_lz_i,
  output logic [SEG_W-1:0]             seg_o,
  output logic [NUM_DIGITS-1:0]        an_o
);

  localparam int unsigned BCD_W = NIBBLE_W * NUM_DIGITS;
  localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SEG_W-1:0]      SEG_POL = {SEG_W{ACTIVE_LOW_SEG}};
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW_AN}};

  logic [BCD_W-1:0]      shadow_val;
  logic                  shadow_blank;
  logic [BCD_W-1:0]      disp_val;
  logic                  disp_blank;
  logic [CNT_W-1:0]      count;
  logic [IDX_W-1:0]      idx;
  bcd_7seg_state_e       state;
  bcd_7seg_state_e       state_next;
  logic [SEG_W-1:0]      seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  logic                  shadow_full_c;
  logic                  accept_c;
  logic                  tick_c;
  logic                  frame_end_c;
  logic [NUM_DIGITS-1:0] lit_c;
  logic [NIBBLE_W-1:0]   digit_c;
  logic [SEG_W-1:0]      glyph_c;

  // Ready is kept as the flop itself; the shadow is full whenever it is low.
  assign shadow_full_c = ~bcd_ready_o;
  assign accept_c      = bcd_valid_i & bcd_ready_o;
  assign tick_c        = (count == CNT_W'(REFRESH_CYCLES - 1));
  assign frame_end_c   = tick_c & (idx == IDX_W'(NUM_DIGITS - 1));

  // Free-running refresh counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      idx   <= '0;
    end else if (tick_c) begin
      count <= '0;
      idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Shadow capture and frame-boundary transfer. Accept is only possible with
  // the shadow empty, so it never collides with a consuming boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val   <= '0;
      shadow_blank <= 1'b0;
      bcd_ready_o  <= 1'b1;
      disp_val     <= '0;
      disp_blank   <= 1'b0;
    end else begin
      if (accept_c) begin
        shadow_val   <= bcd_i;
        shadow_blank <= blank_lz_i;
        bcd_ready_o  <= 1'b0;
      end else if (frame_end_c && shadow_full_c) begin
        bcd_ready_o <= 1'b1;
      end
      if (frame_end_c && shadow_full_c) begin
        disp_val   <= shadow_val;
        disp_blank <= shadow_blank;
      end
    end
  end

  // A digit is lit if blanking is off, it is digit 0, or some digit at or
  // above it is nonzero.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    lit_c = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      if (disp_val[NIBBLE_W*k +: NIBBLE_W] != '0) seen = 1'b1;
      lit_c[k] = seen | ~disp_blank | (k == 0);
    end
  end

  // Select the nibble for the digit currently being scanned.
  always_comb begin
    digit_c = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx == IDX_W'(k)) digit_c = disp_val[NIBBLE_W*k +: NIBBLE_W];
    end
  end

  bcd_to_7seg u_decode (
    .nibble (digit_c),
    .seg    (glyph_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= DARK_S;
    else     state <= state_next;
  end

  // Next state and active-high pin values; dark until the first value lands.
  always_comb begin
    state_next = state;
    seg_next   = SEG_OFF;
    an_next    = '0;
    case (state)
      DARK_S: begin
        if (frame_end_c && shadow_full_c) state_next = SCAN_S;
      end
      SCAN_S: begin
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
          if (idx == IDX_W'(k) && lit_c[k]) begin
            an_next[k] = 1'b1;
            seg_next   = glyph_c;
          end
        end
      end
      default: state_next = DARK_S;
    endcase
  end

  // Pin registers with polarity applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_o <= SEG_POL;
      an_o  <= AN_POL;
    end else begin
      seg_o <= seg_next ^ SEG_POL;
      an_o  <= an_next ^ AN_POL;
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Scoreboard bench: stimulus pushes expected display frames on accept; a
// monitor reconstructs each output frame and pops/compares whenever the
// displayed frame changes.
module tb_bcd_7seg_scan_driver;

  localparam int unsigned N  = 4;
  localparam int unsigned R  = 4;
  localparam int unsigned FR = N * R;

  typedef logic [10:0] slot_t;             // {an[3:0], seg[6:0]}
  typedef logic [N-1:0][10:0] frame_t;     // slot k at index k
  typedef struct {
    frame_t         f;
    logic [N-1:0]   care;                  // compare seg only where set
    string          name;
  } exp_t;

  // Active-low glyphs {g,f,e,d,c,b,a}
  localparam logic [6:0] L_0   = 7'b1000000;
  localparam logic [6:0] L_1   = 7'b1111001;
  localparam logic [6:0] L_2   = 7'b0100100;
  localparam logic [6:0] L_3   = 7'b0110000;
  localparam logic [6:0] L_4   = 7'b0011001;
  localparam logic [6:0] L_5   = 7'b0010010;
  localparam logic [6:0] L_6   = 7'b0000010;
  localparam logic [6:0] L_7   = 7'b1111000;
  localparam logic [6:0] L_8   = 7'b0000000;
  localparam logic [6:0] L_E   = 7'b0000110;
  localparam logic [6:0] L_OFF = 7'b1111111;
  localparam logic [3:0] AN0 = 4'b1110;
  localparam logic [3:0] AN1 = 4'b1101;
  localparam logic [3:0] AN2 = 4'b1011;
  localparam logic [3:0] AN3 = 4'b0111;
  localparam logic [3:0] ANX = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bcd_valid_i = 1'b0;
  logic        bcd_ready_o;
  logic [15:0] bcd_i = '0;
  logic        blank_lz_i = 1'b0;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t exp_q[$];

  bcd_7seg_scan_driver #(
    .NUM_DIGITS     (N),
    .REFRESH_CYCLES (R),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_AN  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bcd_valid_i (bcd_valid_i),
    .bcd_ready_o (bcd_ready_o),
    .bcd_i       (bcd_i),
    .blank_lz_i  (blank_lz_i),
    .seg_o       (seg_o),
    .an_o        (an_o)
  );

  always #5 clk = ~clk;

  // Cycles since the last reset edge; cycle 0 is the first one after it.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic exp_t mk(input string name, input slot_t s3, input slot_t s2,
                              input slot_t s1, input slot_t s0, input logic [3:0] care);
    exp_t e;
    e.f[3] = s3; e.f[2] = s2; e.f[1] = s1; e.f[0] = s0;
    e.care = care;
    e.name = name;
    return e;
  endfunction

  // Monitor: output at cycle c>=1 belongs to slot ((c-1)/R)%N.
  initial begin
    frame_t cur;
    frame_t last;
    bit     have_last;
    int     slot;
    int     pos;
    exp_t   e;
    have_last = 1'b0;
    cur  = '0;
    last = '0;
    forever begin
      @(negedge clk);
      if (cyc == 0) begin
        have_last = 1'b0;
      end else begin
        slot = ((cyc - 1) / R) % N;
        pos  = (cyc - 1) % R;
        if (pos == 0) begin
          cur[slot] = {an_o, seg_o};
        end else if (pos == R - 1) begin
          check($sformatf("slot%0d_stable", slot), 32'({an_o, seg_o}), 32'(cur[slot]));
          if (slot == N - 1 && (!have_last || cur != last)) begin
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 32'(cur), 32'(last));
            end else begin
              e = exp_q.pop_front();
              for (int s = 0; s < N; s++) begin
                check($sformatf("%s_an%0d", e.name, s), 32'(cur[s][10:7]), 32'(e.f[s][10:7]));
                if (e.care[s])
                  check($sformatf("%s_seg%0d", e.name, s), 32'(cur[s][6:0]), 32'(e.f[s][6:0]));
              end
            end
            last      = cur;
            have_last = 1'b1;
          end
        end
      end
    end
  end

  // Offer one value; push its expected frame on accept.
  task automatic send(input logic [15:0] v, input logic bl, input bit do_push,
                      input exp_t e, output int waited);
    @(negedge clk);
    bcd_i       = v;
    blank_lz_i  = bl;
    bcd_valid_i = 1'b1;
    waited      = 0;
    while (!bcd_ready_o && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bcd_ready_o) begin
      check("accept_timeout", 32'(bcd_ready_o), 32'd1);
      bcd_valid_i = 1'b0;
      return;
    end
    // After a stall, ready must come back the cycle after a frame boundary.
    if (waited > 0) check("ready_phase", 32'(cyc % FR), 32'd0);
    if (do_push) exp_q.push_back(e);
    @(negedge clk);
    bcd_valid_i = 1'b0;
    check("ready_low_after_accept", 32'(bcd_ready_o), 32'd0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20 * FR) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  slot_t dark;
  exp_t  dark_e;
  exp_t  none_e;

  initial begin
    int w;
    dark   = {ANX, L_OFF};
    dark_e = mk("dark", dark, dark, dark, dark, 4'b1111);
    none_e = dark_e;

    exp_q.push_back(dark_e);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_an", 32'(an_o), 32'hf);
    check("reset_seg", 32'(seg_o), 32'h7f);
    check("reset_ready", 32'(bcd_ready_o), 32'd1);

    repeat (40) begin
      @(negedge clk);
      check("idle_ready", 32'(bcd_ready_o), 32'd1);
    end

    send(16'h0042, 1'b1, 1'b1,
         mk("v0042", {ANX, L_OFF}, {ANX, L_OFF}, {AN1, L_4}, {AN0, L_2}, 4'b0011), w);

    send(16'h1234, 1'b0, 1'b1,
         mk("v1234", {AN3, L_1}, {AN2, L_2}, {AN1, L_3}, {AN0, L_4}, 4'b1111), w);
    send(16'h5678, 1'b0, 1'b1,
         mk("v5678", {AN3, L_5}, {AN2, L_6}, {AN1, L_7}, {AN0, L_8}, 4'b1111), w);
    check("stall_seen", 32'(w > 0), 32'd1);

    send(16'h00A0, 1'b0, 1'b1,
         mk("v00a0", {AN3, L_0}, {AN2, L_0}, {AN1, L_E}, {AN0, L_0}, 4'b1111), w);
    send(16'h0000, 1'b1, 1'b1,
         mk("v0000", {ANX, L_OFF}, {ANX, L_OFF}, {ANX, L_OFF}, {AN0, L_0}, 4'b0001), w);
    wait_drain("drain_main");

    // Pending value must be discarded by a mid-frame reset.
    send(16'h9999, 1'b0, 1'b0, none_e, w);
    repeat (3) @(negedge clk);
    exp_q.push_back(dark_e);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_an", 32'(an_o), 32'hf);
    check("rst_seg", 32'(seg_o), 32'h7f);
    check("rst_ready", 32'(bcd_ready_o), 32'd1);

    repeat (3 * FR) @(negedge clk);
    check("post_rst_ready", 32'(bcd_ready_o), 32'd1);
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
